uart_tx_buffer: RTL and testbench

//  Transmit-side buffer feeding tx_module inside uart_controller. Accepts bytes

---
 rtl/uart_pkg.sv | 6 +
 rtl/uart_sync_fifo.sv | 43 ++++
 rtl/uart_tx_buffer.sv | 68 ++++++
 tb/tb_uart_tx_buffer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART data width, FIFO depth defaults and tx FSM state encoding.
package uart_pkg;
  localparam int UART_DATA_W_DEF = 8;
  localparam int UART_FIFO_DEPTH_DEF = 16;
  typedef enum logic [1:0] {IDLE, LOAD, START, WAIT_DONE} tx_state_e;
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: power-of-two synchronous FIFO with level count and sync clear.
module uart_sync_fifo #(
  parameter int DW = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic [AW:0]   level,
  output logic          empty,
  output logic          full
);
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  // clear wins over a same-cycle push; a pop frees no room for a same-cycle push
  assign do_push = push && !full && !clr;
  assign do_pop = pop && !empty;
  assign rdata = mem[rd_ptr];
  assign empty = level == '0;
  assign full = level == (AW+1)'(DEPTH);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk_i) if (do_push) mem[wr_ptr] <= wdata;
endmodule

// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: host write FIFO that launches one tx_module frame per stored byte.
module uart_tx_buffer
  import uart_pkg::*;
#(
  parameter int MAX_UART_DATA_W = UART_DATA_W_DEF,
  parameter int FIFO_DEPTH = UART_FIFO_DEPTH_DEF,
  localparam int ADDR_W = $clog2(FIFO_DEPTH)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       enable_i,
  input  logic                       flush_i,
  input  logic                       wr_valid_i,
  input  logic [MAX_UART_DATA_W-1:0] wr_data_i,
  output logic                       wr_ready_o,
  output logic                       tx_start_o,
  output logic [MAX_UART_DATA_W-1:0] tx_data_o,
  input  logic                       tx_done_i,
  output logic [ADDR_W:0]            level_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic                       overflow_o,
  output logic                       busy_o
);
  tx_state_e state;
  logic pop;
  logic [MAX_UART_DATA_W-1:0] rdata;
  assign pop = state == IDLE && enable_i && !empty_o;
  assign wr_ready_o = !full_o;
  assign busy_o = state != IDLE;
  uart_sync_fifo #(.DW(MAX_UART_DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .clr(flush_i),
    .push(wr_valid_i),
    .pop(pop),
    .wdata(wr_data_i),
    .rdata(rdata),
    .level(level_o),
    .empty(empty_o),
    .full(full_o)
  );
  // flush leaves the frame in flight alone; only the queued words are dropped
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      tx_start_o <= 1'b0;
      tx_data_o <= '0;
    end else begin
      tx_start_o <= state == LOAD;
      case (state)
        IDLE: if (pop) begin
          state <= LOAD;
          tx_data_o <= rdata;
        end
        LOAD: state <= START;
        START: state <= WAIT_DONE;
        WAIT_DONE: if (tx_done_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) overflow_o <= 1'b0;
    else if (flush_i) overflow_o <= 1'b0;
    else if (wr_valid_i && full_o) overflow_o <= 1'b1;
  end
endmodule

// File: tb/tb_uart_tx_buffer.sv
// tb_uart_tx_buffer: directed stimulus with a frame scoreboard and a tx_module responder.
module tb_uart_tx_buffer;
  logic clk, rst_ni, enable, flush, wr_valid, wr_ready, tx_start, tx_done, model_done, spur_done;
  logic empty, full, overflow, busy;
  logic [7:0] wr_data, tx_data;
  logic [4:0] level;
  logic [7:0] exp_q[$];
  int total = 0, bad = 0, done_delay = 4;
  assign tx_done = model_done | spur_done;
  uart_tx_buffer dut (
    .clk_i(clk), .rst_ni(rst_ni), .enable_i(enable), .flush_i(flush),
    .wr_valid_i(wr_valid), .wr_data_i(wr_data), .wr_ready_o(wr_ready),
    .tx_start_o(tx_start), .tx_data_o(tx_data), .tx_done_i(tx_done),
    .level_o(level), .empty_o(empty), .full_o(full), .overflow_o(overflow), .busy_o(busy)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic write(input logic [7:0] d, input logic ok);
    wr_valid = 1;
    wr_data = d;
    check("wr_ready", wr_ready, ok);
    if (ok) exp_q.push_back(d);
    tick(1);
    wr_valid = 0;
  endtask
  task automatic drain(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && !busy && empty) break;
      tick(1);
    end
    check("drain_in_time", i < budget, 1);
  endtask
  // tx_module stand-in: done pulse done_delay cycles after each start
  initial begin
    model_done = 0;
    forever begin
      @(negedge clk);
      if (rst_ni && tx_start) begin
        repeat (done_delay) @(posedge clk);
        #1 model_done = 1;
        @(posedge clk);
        #1 model_done = 0;
      end
    end
  end
  // monitor: every start pops the scoreboard; data must hold until done
  initial begin
    logic [7:0] cur;
    logic in_frame, prev_start;
    in_frame = 0;
    prev_start = 0;
    cur = '0;
    forever begin
      @(negedge clk);
      if (!rst_ni) in_frame = 0;
      else begin
        if (tx_start) begin
          check("start_single_pulse", prev_start, 0);
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_start: got data %0h expected no start", tx_data);
          end else begin
            cur = exp_q.pop_front();
            check("frame_data", tx_data, cur);
            in_frame = 1;
          end
        end else if (in_frame) check("data_hold", tx_data, cur);
        if (model_done) in_frame = 0;
      end
      prev_start = tx_start;
    end
  end
  initial begin
    rst_ni = 0; enable = 0; flush = 0; wr_valid = 0; wr_data = 0; spur_done = 0;
    #1;
    check("rst_level", level, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_ready", wr_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_start", tx_start, 0);
    check("rst_data", tx_data, 0);
    check("rst_overflow", overflow, 0);
    @(posedge clk);
    #1 rst_ni = 1;
    tick(1);
    // reset while a frame waits for done with three words queued
    enable = 1; done_delay = 30;
    write(8'h11, 1); write(8'h22, 1); write(8'h33, 1); write(8'h44, 1);
    tick(4);
    check("t1_level_before", level, 3);
    check("t1_busy_before", busy, 1);
    rst_ni = 0;
    exp_q.delete();
    #1;
    check("t1_rst_level", level, 0);
    check("t1_rst_empty", empty, 1);
    check("t1_rst_busy", busy, 0);
    check("t1_rst_start", tx_start, 0);
    check("t1_rst_data", tx_data, 0);
    check("t1_rst_ready", wr_ready, 1);
    @(posedge clk);
    #1 rst_ni = 1;
    tick(45);
    check("t1_quiet_busy", busy, 0);
    // single frame: start three cycles after push, done twenty after start
    done_delay = 20;
    write(8'hA5, 1);
    check("t2_level_n1", level, 1);
    check("t2_start_n1", tx_start, 0);
    tick(1);
    check("t2_level_n2", level, 0);
    check("t2_start_n2", tx_start, 0);
    check("t2_busy_n2", busy, 1);
    tick(1);
    check("t2_start_n3", tx_start, 1);
    check("t2_data_n3", tx_data, 8'hA5);
    tick(20);
    check("t2_busy_at_done", busy, 1);
    check("t2_data_at_done", tx_data, 8'hA5);
    tick(1);
    check("t2_idle_after_done", busy, 0);
    // fill with launching disabled, then overflow
    enable = 0; done_delay = 4;
    for (int i = 0; i < 16; i++) write(8'(i), 1);
    check("t3_full", full, 1);
    check("t3_level16", level, 16);
    check("t3_overflow_clear", overflow, 0);
    write(8'h55, 0);
    check("t3_overflow_set", overflow, 1);
    check("t3_level_after_ovf", level, 16);
    // pop from full plus same-cycle write: write is rejected
    enable = 1;
    write(8'h77, 0);
    check("t4_level15", level, 15);
    check("t4_full_clear", full, 0);
    drain(400);
    check("t3_level_drained", level, 0);
    check("t3_overflow_sticky", overflow, 1);
    // flush during a frame with five words queued
    enable = 0; done_delay = 25;
    for (int i = 0; i < 6; i++) write(8'hA0 + 8'(i), 1);
    enable = 1;
    tick(4);
    check("t5_busy_before", busy, 1);
    check("t5_level_before", level, 5);
    flush = 1; wr_valid = 1; wr_data = 8'hEE;
    tick(1);
    flush = 0; wr_valid = 0;
    exp_q.delete();
    check("t5_level_flushed", level, 0);
    check("t5_empty_flushed", empty, 1);
    check("t5_overflow_flushed", overflow, 0);
    check("t5_frame_continues", busy, 1);
    drain(100);
    tick(10);
    check("t5_no_more_frames", busy, 0);
    // spurious done in IDLE (with a word held back) and in START
    enable = 0; done_delay = 10;
    write(8'h5A, 1);
    spur_done = 1;
    tick(1);
    spur_done = 0;
    check("t6_idle_spur_busy", busy, 0);
    check("t6_idle_spur_level", level, 1);
    enable = 1;
    tick(2);
    check("t6_start", tx_start, 1);
    spur_done = 1;
    tick(1);
    spur_done = 0;
    tick(3);
    check("t6_start_spur_busy", busy, 1);
    drain(100);
    // pointer wrap: four bursts of ten words
    done_delay = 1;
    for (int r = 0; r < 4; r++) begin
      enable = 0;
      for (int i = 0; i < 10; i++) write(8'(r * 10 + i) ^ 8'h3C, 1);
      check("t6_wrap_level", level, 10);
      enable = 1;
      drain(200);
      check("t6_wrap_empty", level, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
